lut_cell_k: RTL and testbench

- Next-generation fabric logic cell: a K-input LUT with an optional output register.
- Configured through a serial chain clocked by the main clock and gated by a shift-enable, instead of a separate configuration clock.
- Adds an FF init value, optional clock-enable use, and a load-status FSM reporting whether exactly the right number of config bits were shifted.
- Cells chain through cfg_in_i/cfg_out_o to form the fabric config chain.

---
 rtl/lut_cell_k.sv | 99 +++++++++
 tb/tb_lut_cell_k.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_cell_k.sv
// K-input LUT cell with optional output register, serial config chain on the main clock,
// and a load-status FSM that flags config sessions with the wrong bit count.
module lut_cell_k #(
    parameter int K = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [K-1:0] inputs_i,
    input  logic         ce_i,
    input  logic         cfg_en_i,
    input  logic         cfg_in_i,
    output logic         cfg_out_o,
    output logic         out_o,
    output logic         ready_o,
    output logic         cfg_err_o
);

    localparam int LUT_BITS = 1 << K;
    localparam int CFG_BITS = LUT_BITS + 3;
    localparam int CW       = $clog2(CFG_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CFG_BITS + 1);

    typedef enum logic [1:0] {UNCFG, SHIFT, INIT, RUN} state_t;

    state_t                state_q, state_d;
    logic [CFG_BITS-1:0]   cfg_sr_q, cfg_sr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  q_q, q_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;

    logic [LUT_BITS-1:0]   lut_tbl;
    logic                  lut_out;
    logic                  use_reg, init_val, ce_use;

    assign lut_tbl  = cfg_sr_q[LUT_BITS-1:0];
    assign lut_out  = lut_tbl[inputs_i];
    assign use_reg  = cfg_sr_q[LUT_BITS];
    assign init_val = cfg_sr_q[LUT_BITS+1];
    assign ce_use   = cfg_sr_q[LUT_BITS+2];

    always_comb begin
        state_d  = state_q;
        cfg_sr_d = cfg_sr_q;
        cnt_d    = cnt_q;
        q_d      = q_q;

        if (cfg_en_i) begin
            state_d  = SHIFT;
            cfg_sr_d = {cfg_sr_q[CFG_BITS-2:0], cfg_in_i};
            if (state_q != SHIFT) begin
                cnt_d = CW'(1);
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            case (state_q)
                SHIFT:   state_d = INIT;
                INIT:    state_d = RUN;
                default: state_d = state_q;
            endcase
        end

        // The output register follows the current state, independent of a new shift request.
        case (state_q)
            INIT: q_d = init_val;
            RUN:  if (!ce_use || ce_i) q_d = lut_out;
            default: q_d = q_q;
        endcase

        ready_d = (state_d == RUN) && (cnt_d == CNT_FULL);
        err_d   = ((state_d == INIT) || (state_d == RUN)) && (cnt_d != CNT_FULL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= UNCFG;
            cfg_sr_q <= '0;
            cnt_q    <= '0;
            q_q      <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_sr_q <= cfg_sr_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign cfg_out_o = cfg_sr_q[CFG_BITS-1];
    assign ready_o   = ready_q;
    assign cfg_err_o = err_q;
    assign out_o     = (state_q == RUN) ? (use_reg ? q_q : lut_out) : 1'b0;

endmodule

// File: tb/tb_lut_cell_k.sv
// Directed bench for lut_cell_k: stimulus pushes expectations, a negedge monitor pops and checks.
module tb_lut_cell_k;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] inputs = 2'd0;
    logic       ce = 1'b0;
    logic       cfg_en = 1'b0;
    logic       cfg_en_b = 1'b0;
    logic       cfg_in = 1'b0;
    logic       cfg_out_a, out_a, ready_a, err_a;
    logic       cfg_out_b, out_b, ready_b, err_b;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    typedef struct {
        string name;
        int    sig;
        logic  val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lut_cell_k #(.K(2)) u_a (
        .clk_i(clk), .rst_i(rst), .inputs_i(inputs), .ce_i(ce),
        .cfg_en_i(cfg_en), .cfg_in_i(cfg_in), .cfg_out_o(cfg_out_a),
        .out_o(out_a), .ready_o(ready_a), .cfg_err_o(err_a)
    );

    lut_cell_k #(.K(2)) u_b (
        .clk_i(clk), .rst_i(rst), .inputs_i(inputs), .ce_i(ce),
        .cfg_en_i(cfg_en_b), .cfg_in_i(cfg_out_a), .cfg_out_o(cfg_out_b),
        .out_o(out_b), .ready_o(ready_b), .cfg_err_o(err_b)
    );

    function automatic logic pick(input int s);
        case (s)
            0: return out_a;
            1: return ready_a;
            2: return err_a;
            3: return cfg_out_a;
            4: return out_b;
            5: return ready_b;
            6: return (u_a.cfg_sr_q == '0);
            default: return err_b;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = pick(e.sig);
            total++;
            if (act !== e.val) begin
                bad++;
                $display("FAIL %s: got %b want %b at %0t", e.name, act, e.val, $time);
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: test did not complete at %0t", $time);
            $finish;
        end
    end

    task automatic check_now(input string n, input int s, input logic v);
        logic act;
        act = pick(s);
        total++;
        if (act !== v) begin
            bad++;
            $display("FAIL %s (direct): got %b want %b at %0t", n, act, v, $time);
        end
    endtask

    task automatic expect_sig(input string n, input int s, input logic v);
        exp_t e;
        e.name = n;
        e.sig  = s;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bits[n-1] is shifted first (lands in ce_use for a 7-bit session)
    task automatic shift_seq(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_en = 1'b1;
            cfg_in = bits[i];
            tick();
            if (i == n - 1) begin
                expect_sig("shift_out0", 0, 1'b0);
                expect_sig("shift_rdy0", 1, 1'b0);
                expect_sig("shift_err0", 2, 1'b0);
            end
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic finish_cfg(input logic exp_rdy, input logic exp_err);
        expect_sig("last_shift_out", 0, 1'b0);
        expect_sig("last_shift_rdy", 1, 1'b0);
        tick();
        expect_sig("init_out", 0, 1'b0);
        expect_sig("init_rdy", 1, 1'b0);
        expect_sig("init_err", 2, exp_err);
        tick();
        expect_sig("run_rdy", 1, exp_rdy);
        expect_sig("run_err", 2, exp_err);
    endtask

    initial begin
        logic [13:0] chain_pat;
        logic [13:0] cpat;

        // reset state
        tick();
        tick();
        check_now("rst_out_now", 0, 1'b0);
        check_now("rst_rdy_now", 1, 1'b0);
        check_now("rst_err_now", 2, 1'b0);
        check_now("rst_sr_zero_now", 6, 1'b1);
        expect_sig("rst_out", 0, 1'b0);
        expect_sig("rst_cfgout", 3, 1'b0);
        expect_sig("rst_rdy", 1, 1'b0);
        expect_sig("rst_err", 2, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // AND, combinational
        shift_seq(16'b0001000, 7);
        finish_cfg(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            inputs = 2'(i);
            expect_sig("and_comb", 0, (i == 3));
            tick();
        end

        // XOR, registered, init=1
        shift_seq(16'b0110110, 7);
        finish_cfg(1'b1, 1'b0);
        inputs = 2'd0;
        expect_sig("xor_init", 0, 1'b1);
        tick();
        expect_sig("xor_reg_0", 0, 1'b0);
        inputs = 2'd1;
        expect_sig("xor_hold", 0, 1'b0);
        tick();
        expect_sig("xor_reg_1", 0, 1'b1);
        inputs = 2'd3;
        tick();
        expect_sig("xor_reg_3", 0, 1'b0);

        // clock enable honoured
        shift_seq(16'b1110110, 7);
        finish_cfg(1'b1, 1'b0);
        ce = 1'b0;
        expect_sig("ce_init", 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            inputs = 2'(i % 4);
            tick();
            expect_sig("ce_hold", 0, 1'b1);
        end
        inputs = 2'd0;
        ce = 1'b1;
        tick();
        expect_sig("ce_upd_0", 0, 1'b0);
        inputs = 2'd1;
        tick();
        expect_sig("ce_upd_1", 0, 1'b1);
        ce = 1'b0;

        // short session: previous cfg_sr[0]=0 ends up in ce_use, rest is AND
        shift_seq(16'b001000, 6);
        finish_cfg(1'b0, 1'b1);
        inputs = 2'd3;
        expect_sig("short_out3", 0, 1'b1);
        tick();
        inputs = 2'd2;
        expect_sig("short_out2", 0, 1'b0);
        tick();

        // long session: last 7 bits give out = ~inputs[1]
        shift_seq(16'b000000011, 9);
        finish_cfg(1'b0, 1'b1);
        inputs = 2'd0;
        expect_sig("long_out0", 0, 1'b1);
        tick();
        inputs = 2'd3;
        expect_sig("long_out3", 0, 1'b0);
        tick();

        // correct session clears the error
        shift_seq(16'b0001000, 7);
        finish_cfg(1'b1, 1'b0);
        inputs = 2'd3;
        expect_sig("recfg_and", 0, 1'b1);
        tick();

        // chain: first 7 bits (AND) pass through a into b, last 7 (OR) stay in a
        chain_pat = 14'b0001000_0001110;
        for (int i = 13; i >= 0; i--) begin
            cfg_en   = 1'b1;
            cfg_en_b = (i <= 6);
            cfg_in   = chain_pat[i];
            tick();
            if (14 - i >= 7) begin
                cpat = chain_pat;
                expect_sig("chain_cfgout", 3, cpat[13 - (14 - i - 7)]);
            end
        end
        cfg_en   = 1'b0;
        cfg_en_b = 1'b0;
        cfg_in   = 1'b0;
        tick();
        tick();
        expect_sig("chain_rdy_b", 5, 1'b1);
        expect_sig("chain_err_b", 7, 1'b0);
        expect_sig("chain_err_a", 2, 1'b1);
        expect_sig("chain_rdy_a", 1, 1'b0);
        inputs = 2'd0;
        expect_sig("chain_a0", 0, 1'b0);
        expect_sig("chain_b0", 4, 1'b0);
        tick();
        inputs = 2'd1;
        expect_sig("chain_a1", 0, 1'b1);
        expect_sig("chain_b1", 4, 1'b0);
        tick();
        inputs = 2'd3;
        expect_sig("chain_a3", 0, 1'b1);
        expect_sig("chain_b3", 4, 1'b1);
        tick();

        // reset mid-shift after 3 bits, with cfg_en still high
        for (int i = 0; i < 3; i++) begin
            cfg_en = 1'b1;
            cfg_in = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        expect_sig("abort_out", 0, 1'b0);
        expect_sig("abort_rdy", 1, 1'b0);
        expect_sig("abort_err", 2, 1'b0);
        expect_sig("abort_cfgout", 3, 1'b0);
        expect_sig("abort_sr_zero", 6, 1'b1);
        rst = 1'b0;
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        tick();
        shift_seq(16'b0001000, 7);
        finish_cfg(1'b1, 1'b0);
        inputs = 2'd3;
        expect_sig("fresh_and", 0, 1'b1);
        tick();

        @(negedge clk);
        #1;
        done = 1'b1;
        if (bad != 0) begin
            $display("FAIL: %0d of %0d checks failed", bad, total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
